// File: rtl/ov7670_pkg.sv
// Shared camera/frame definitions: capture FSM states, default frame geometry
// and the RGB565 -> RGB888 expansion used by the capture and compression stages.
package ov7670_pkg;

   localparam int unsigned DEF_IM_WIDTH   = 640;
   localparam int unsigned DEF_IM_HEIGHT  = 480;
   localparam int unsigned DEF_OUT_DATA_W = 24;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      ACTIVE,
      CHECK
   } cap_state_e;

   // Replicate the MSBs into the new LSBs so full-scale stays full-scale.
   function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
      return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
   endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// N-stage synchroniser for one asynchronous camera control line, with
// single-cycle rise/fall pulses derived from the synchronised copy.
module cam_sync_edge #(
   parameter int unsigned pSTAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic id,
   output logic oq,
   output logic orise,
   output logic ofall
);

   logic [pSTAGES-1:0] sync_q, sync_d;
   logic               prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[pSTAGES-2:0], id};
      prev_d = sync_q[pSTAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign oq    = sync_q[pSTAGES-1];
   assign orise =  sync_q[pSTAGES-1] & ~prev_q;
   assign ofall = ~sync_q[pSTAGES-1] &  prev_q;

endmodule

// File: rtl/ov7670_frame_capture.sv
// OV7670 parallel-bus capture: RGB565 byte pairs -> RGB888 pixels written into a
// double-buffered frame memory, publishing each clean frame's base address.
module ov7670_frame_capture
   import ov7670_pkg::*;
#(
   parameter  int unsigned pIM_WIDTH    = DEF_IM_WIDTH,
   parameter  int unsigned pIM_HEIGHT   = DEF_IM_HEIGHT,
   parameter  int unsigned pOUT_DATA_W  = DEF_OUT_DATA_W,
   parameter  int unsigned pSYNC_STAGES = 2,
   localparam int unsigned lpFRAME_PX   = pIM_WIDTH * pIM_HEIGHT,
   localparam int unsigned lpAW         = $clog2(2 * lpFRAME_PX)
) (
   input  logic                   iclk,
   input  logic                   irst_n,
   input  logic                   icam_pclk,
   input  logic                   icam_vsync,
   input  logic                   icam_href,
   input  logic [7:0]             icam_data,
   input  logic                   icapture_en,
   input  logic                   iconsumer_busy,
   output logic [pOUT_DATA_W-1:0] odata_wr,
   output logic [lpAW-1:0]        oaddr_wr,
   output logic                   omem_wr_en,
   output logic [lpAW-1:0]        oframe_ptr,
   output logic                   oframe_done,
   output logic                   oframe_drop,
   output logic                   oframe_err,
   output logic                   obusy
);

   localparam int unsigned lpCW = $clog2(pIM_WIDTH + 1);
   localparam int unsigned lpRW = $clog2(pIM_HEIGHT + 1);
   localparam logic [lpCW-1:0] lpW_C     = lpCW'(pIM_WIDTH);
   localparam logic [lpRW-1:0] lpH_C     = lpRW'(pIM_HEIGHT);
   localparam logic [lpAW-1:0] lpFRAME_A = lpAW'(lpFRAME_PX);

   // Reset asserts asynchronously, deasserts only after two clean iclk edges.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n_int;

   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) rst_sync_q <= '0;
      else         rst_sync_q <= rst_sync_d;
   end

   assign rst_n_int = rst_sync_q[1];

   logic pclk_lvl, pclk_rise, pclk_fall;
   logic vsync_lvl, vsync_rise, vsync_fall;
   logic href_lvl, href_rise, href_fall;
   logic unused_sync;

   cam_sync_edge #(.pSTAGES(pSYNC_STAGES)) u_sync_pclk (
      .clk(iclk), .rst_n(rst_n_int), .id(icam_pclk),
      .oq(pclk_lvl), .orise(pclk_rise), .ofall(pclk_fall));

   cam_sync_edge #(.pSTAGES(pSYNC_STAGES)) u_sync_vsync (
      .clk(iclk), .rst_n(rst_n_int), .id(icam_vsync),
      .oq(vsync_lvl), .orise(vsync_rise), .ofall(vsync_fall));

   cam_sync_edge #(.pSTAGES(pSYNC_STAGES)) u_sync_href (
      .clk(iclk), .rst_n(rst_n_int), .id(icam_href),
      .oq(href_lvl), .orise(href_rise), .ofall(href_fall));

   assign unused_sync = ^{pclk_lvl, pclk_fall, vsync_lvl, href_rise};

   // Data follows the same depth as pclk so it lines up with the rise pulse.
   logic [pSYNC_STAGES-1:0][7:0] dsync_q, dsync_d;
   logic [7:0]                   data_sync;

   always_comb dsync_d = {dsync_q[pSYNC_STAGES-2:0], icam_data};
   assign data_sync = dsync_q[pSYNC_STAGES-1];

   cap_state_e              state_q, state_d;
   logic                    wsel_q, wsel_d;
   logic [lpAW-1:0]         off_q, off_d;
   logic [lpCW-1:0]         col_q, col_d;
   logic [lpRW-1:0]         row_q, row_d;
   logic                    phase_q, phase_d;
   logic [7:0]              hi_q, hi_d;
   logic                    short_q, short_d;
   logic [pOUT_DATA_W-1:0]  data_q, data_d;
   logic [lpAW-1:0]         addr_q, addr_d;
   logic                    wr_en_q, wr_en_d;
   logic [lpAW-1:0]         ptr_q, ptr_d;
   logic                    done_q, done_d;
   logic                    drop_q, drop_d;
   logic                    err_q, err_d;
   logic                    line_end;

   always_comb begin
      state_d  = state_q;
      wsel_d   = wsel_q;
      off_d    = off_q;
      col_d    = col_q;
      row_d    = row_q;
      phase_d  = phase_q;
      hi_d     = hi_q;
      short_d  = short_q;
      data_d   = data_q;
      addr_d   = addr_q;
      wr_en_d  = 1'b0;
      ptr_d    = ptr_q;
      done_d   = 1'b0;
      drop_d   = 1'b0;
      err_d    = 1'b0;
      // vsync rising with href still high closes the line before the frame.
      line_end = href_fall | (vsync_rise & href_lvl);

      case (state_q)
         IDLE: if (icapture_en) state_d = ARM;
         ARM: begin
            if (vsync_fall) begin
               state_d = ACTIVE;
               off_d   = '0;
               col_d   = '0;
               row_d   = '0;
               phase_d = 1'b0;
               short_d = 1'b0;
            end
         end
         ACTIVE: begin
            if (line_end) begin
               if (col_q < lpW_C && row_q < lpH_C) short_d = 1'b1;
               if (row_q < lpH_C) row_d = row_q + 1'b1;
               col_d   = '0;
               phase_d = 1'b0;
            end else if (pclk_rise && href_lvl) begin
               if (!phase_q) begin
                  hi_d    = data_sync;
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (col_q < lpW_C) begin
                     col_d = col_q + 1'b1;
                     if (row_q < lpH_C) begin
                        wr_en_d = 1'b1;
                        data_d  = pOUT_DATA_W'(rgb565_to_888({hi_q, data_sync}));
                        addr_d  = (wsel_q ? lpFRAME_A : '0) + off_q;
                        off_d   = off_q + 1'b1;
                     end
                  end
               end
            end
            if (vsync_rise) state_d = CHECK;
         end
         CHECK: begin
            if (short_q || row_q < lpH_C) begin
               err_d = 1'b1;
            end else if (iconsumer_busy) begin
               drop_d = 1'b1;
            end else begin
               ptr_d  = wsel_q ? lpFRAME_A : '0;
               wsel_d = ~wsel_q;
               done_d = 1'b1;
            end
            state_d = icapture_en ? ARM : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iclk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         dsync_q <= '0;
         state_q <= IDLE;
         wsel_q  <= 1'b0;
         off_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         phase_q <= 1'b0;
         hi_q    <= '0;
         short_q <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
         wr_en_q <= 1'b0;
         ptr_q   <= '0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         dsync_q <= dsync_d;
         state_q <= state_d;
         wsel_q  <= wsel_d;
         off_q   <= off_d;
         col_q   <= col_d;
         row_q   <= row_d;
         phase_q <= phase_d;
         hi_q    <= hi_d;
         short_q <= short_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         wr_en_q <= wr_en_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
         err_q   <= err_d;
      end
   end

   assign odata_wr    = data_q;
   assign oaddr_wr    = addr_q;
   assign omem_wr_en  = wr_en_q;
   assign oframe_ptr  = ptr_q;
   assign oframe_done = done_q;
   assign oframe_drop = drop_q;
   assign oframe_err  = err_q;
   assign obusy       = (state_q == ARM) || (state_q == ACTIVE);

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Directed bench for ov7670_frame_capture on a reduced 6x4 frame, checked
// against a frame-level model of expected writes and end-of-frame events.
module tb_ov7670_frame_capture;

   localparam int W  = 6;
   localparam int H  = 4;
   localparam int FP = W * H;
   localparam int AW = $clog2(2 * FP);

   logic          iclk = 1'b0;
   logic          irst_n = 1'b0;
   logic          icam_pclk = 1'b0;
   logic          icam_vsync = 1'b1;
   logic          icam_href = 1'b0;
   logic [7:0]    icam_data = 8'h00;
   logic          icapture_en = 1'b0;
   logic          iconsumer_busy = 1'b0;
   logic [23:0]   odata_wr;
   logic [AW-1:0] oaddr_wr;
   logic          omem_wr_en;
   logic [AW-1:0] oframe_ptr;
   logic          oframe_done, oframe_drop, oframe_err, obusy;

   always #5 iclk = ~iclk;

   ov7670_frame_capture #(
      .pIM_WIDTH(W), .pIM_HEIGHT(H), .pOUT_DATA_W(24), .pSYNC_STAGES(2)
   ) dut (
      .iclk(iclk), .irst_n(irst_n), .icam_pclk(icam_pclk), .icam_vsync(icam_vsync),
      .icam_href(icam_href), .icam_data(icam_data), .icapture_en(icapture_en),
      .iconsumer_busy(iconsumer_busy), .odata_wr(odata_wr), .oaddr_wr(oaddr_wr),
      .omem_wr_en(omem_wr_en), .oframe_ptr(oframe_ptr), .oframe_done(oframe_done),
      .oframe_drop(oframe_drop), .oframe_err(oframe_err), .obusy(obusy)
   );

   int          checks = 0, errors = 0;
   int          exp_addr[$];
   logic [23:0] exp_data[$];
   int          exp_evt[$];   // 4 = done, 2 = drop, 1 = err
   int          exp_ptr[$];
   int          evt_seen = 0, evt_exp = 0;
   int          m_wsel = 0, m_ptr = 0, m_off = 0;
   bit          armed = 0;
   int          last_addr = -1;
   logic [23:0] last_data = '0;
   int          mon_code;

   function automatic logic [23:0] expand(input logic [15:0] p);
      int r, g, b;
      r = int'(p[15:11]); g = int'(p[10:5]); b = int'(p[4:0]);
      r = r * 8 + r / 4;
      g = g * 4 + g / 16;
      b = b * 8 + b / 4;
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge iclk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      icam_data = b;
      cyc(1);
      icam_pclk = 1'b1;
      cyc(2);
      icam_pclk = 1'b0;
      cyc(1);
   endtask

   always @(negedge iclk) begin
      if (omem_wr_en) begin
         if (exp_addr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr %0d data %06h, no write expected", oaddr_wr, odata_wr);
         end else begin
            chk("wr_addr", oaddr_wr, exp_addr.pop_front());
            chk("wr_data", odata_wr, exp_data.pop_front());
         end
         last_addr = int'(oaddr_wr);
         last_data = odata_wr;
      end
      if (oframe_done | oframe_drop | oframe_err) begin
         mon_code = {29'd0, oframe_done, oframe_drop, oframe_err};
         evt_seen++;
         if (exp_evt.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: code %0d, no event expected", mon_code);
         end else begin
            chk("frame_event", mon_code, exp_evt.pop_front());
            chk("frame_ptr", oframe_ptr, exp_ptr.pop_front());
         end
      end
   end

   // One frame; odd_row gets odd_len pixels, rst_row/en_row inject reset or capture-disable.
   task automatic frame(input int nlines, input int odd_row, input int odd_len,
                        input logic [15:0] color, input logic busy,
                        input int rst_row, input int en_row);
      bit cap, bad;
      int len;
      cap = armed;
      bad = (nlines < H);
      if (cap) m_off = 0;
      icam_vsync = 1'b1; cyc(8);
      icam_vsync = 1'b0; cyc(8);
      for (int r = 0; r < nlines; r++) begin
         if (r == rst_row) begin
            irst_n = 1'b0;
            #1;
            chk("rst_wr_en", omem_wr_en, 0);
            chk("rst_ptr", oframe_ptr, 0);
            chk("rst_addr", oaddr_wr, 0);
            chk("rst_data", odata_wr, 0);
            chk("rst_busy", obusy, 0);
            chk("rst_drained", exp_addr.size(), 0);
            cap = 0; m_wsel = 0; m_ptr = 0;
            cyc(3);
            irst_n = 1'b1;
         end
         if (r == en_row) icapture_en = 1'b0;
         len = (r == odd_row) ? odd_len : W;
         if (r < H && len < W) bad = 1;
         if (cap && r < H) begin
            for (int c = 0; c < len && c < W; c++) begin
               exp_addr.push_back(m_wsel * FP + m_off);
               exp_data.push_back(expand(color));
               m_off++;
            end
         end
         icam_href = 1'b1; cyc(3);
         for (int c = 0; c < len; c++) begin
            send_byte(color[15:8]);
            send_byte(color[7:0]);
         end
         cyc(3);
         icam_href = 1'b0; cyc(6);
      end
      iconsumer_busy = busy;
      if (cap) begin
         if (bad) begin
            exp_evt.push_back(1);
         end else if (busy) begin
            exp_evt.push_back(2);
         end else begin
            m_ptr  = m_wsel * FP;
            m_wsel = 1 - m_wsel;
            exp_evt.push_back(4);
         end
         exp_ptr.push_back(m_ptr);
         evt_exp++;
      end
      cyc(2);
      icam_vsync = 1'b1;
      for (int i = 0; i < 40 && evt_seen != evt_exp; i++) cyc(1);
      chk("frame_event_seen", evt_seen, evt_exp);
      chk("writes_drained", exp_addr.size(), 0);
      iconsumer_busy = 1'b0;
      armed = icapture_en;
   endtask

   initial begin
      cyc(3);
      chk("init_wr_en", omem_wr_en, 0);
      chk("init_ptr", oframe_ptr, 0);
      chk("init_busy", obusy, 0);
      chk("init_done", oframe_done, 0);
      irst_n = 1'b1;
      icapture_en = 1'b1;
      cyc(4);
      armed = 1;
      chk("armed_busy", obusy, 1);

      frame(H, -1, 0, 16'hF800, 1'b0, -1, -1);
      chk("f1_ptr", oframe_ptr, 0);
      chk("f1_last_addr", last_addr, FP - 1);
      chk("f1_last_data", last_data, 24'hFF0000);

      frame(H, -1, 0, 16'h07E0, 1'b0, -1, -1);
      chk("f2_ptr", oframe_ptr, FP);
      chk("f2_last_addr", last_addr, 2 * FP - 1);
      chk("f2_last_data", last_data, 24'h00FF00);

      frame(H, -1, 0, 16'h001F, 1'b0, -1, -1);
      chk("f3_ptr", oframe_ptr, 0);
      chk("f3_last_addr", last_addr, FP - 1);
      chk("f3_last_data", last_data, 24'h0000FF);

      frame(H, -1, 0, 16'h8410, 1'b1, -1, -1);
      chk("drop_ptr", oframe_ptr, 0);
      chk("drop_last_addr", last_addr, 2 * FP - 1);
      chk("drop_last_data", last_data, 24'h848284);

      frame(H, -1, 0, 16'h1234, 1'b0, -1, -1);
      chk("rewrite_ptr", oframe_ptr, FP);

      frame(H, -1, 0, 16'hABCD, 1'b0, 2, -1);
      chk("post_rst_ptr", oframe_ptr, 0);

      frame(H, -1, 0, 16'h5555, 1'b0, -1, -1);
      chk("post_rst_frame_ptr", oframe_ptr, 0);
      chk("post_rst_last_addr", last_addr, FP - 1);

      frame(H, 1, W - 1, 16'hAAAA, 1'b0, -1, -1);
      chk("short_line_ptr", oframe_ptr, 0);

      frame(H - 1, -1, 0, 16'h6666, 1'b0, -1, -1);
      chk("short_frame_ptr", oframe_ptr, 0);

      frame(H, 2, W + 1, 16'h9999, 1'b0, -1, -1);
      chk("long_line_ptr", oframe_ptr, FP);
      chk("long_line_last_addr", last_addr, 2 * FP - 1);

      frame(H, -1, 0, 16'hC3C3, 1'b0, -1, 1);
      chk("en_drop_ptr", oframe_ptr, 0);
      cyc(4);
      chk("en_drop_idle", obusy, 0);

      frame(H, -1, 0, 16'h0F0F, 1'b0, -1, -1);
      chk("idle_busy", obusy, 0);
      chk("idle_ptr", oframe_ptr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
